// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI byte transceiver.
package spi_pkg;

  localparam int SPI_BITS_PER_BYTE = 8;
  localparam logic [SPI_BITS_PER_BYTE-1:0] IDLE_TX_DFLT = 8'h00;

  typedef logic [2:0] bit_cnt_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop pin synchroniser with a history flop for single-cycle edge pulses.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      hist_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
      hist_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_byte_trx.sv
// Mode-0 MSB-first SPI slave: byte receive with pop strobe, one response byte per slot on miso.
module spi_byte_trx
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = IDLE_TX_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       rst_o,
  output logic [7:0] data_o,
  output logic       ack_pop_o,
  input  logic [7:0] data_i,
  input  logic       ack_i,
  output logic       tx_underrun_o
);

  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(SPI_BITS_PER_BYTE - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic unused_ss_edges;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_lvl;

  bit_cnt_t   bit_cnt;
  logic [7:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] hold_q;
  logic       hold_vld;
  logic       byte_done;
  logic       slot_pend;
  logic       slot_edge;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .pin(sck), .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  // ss resets to deselected so the engine is held in reset until a real select arrives.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .pin(ss), .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  // Deselect is level-driven, so a mid-byte ss rise needs no special handling.
  assign unused_ss_edges = ss_rise | ss_fall | sck_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_lvl  = mosi_sync_q[SYNC_STAGES-1];
  assign slot_edge = sck_fall && slot_pend && (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_o         <= 1'b1;
      data_o        <= 8'h00;
      ack_pop_o     <= 1'b0;
      miso          <= 1'b0;
      tx_underrun_o <= 1'b0;
      bit_cnt       <= '0;
      rx_sr         <= 8'h00;
      tx_sr         <= IDLE_TX;
      hold_q        <= 8'h00;
      hold_vld      <= 1'b0;
      byte_done     <= 1'b0;
      slot_pend     <= 1'b0;
    end else begin
      // NOTE: strobes default low here with non-blocking assigns; a later assign in this block wins.
      ack_pop_o     <= 1'b0;
      tx_underrun_o <= 1'b0;
      byte_done     <= 1'b0;
      rst_o         <= ss_lvl;
      miso          <= ss_lvl ? 1'b0 : tx_sr[7];

      if (byte_done) begin
        data_o    <= rx_sr;
        ack_pop_o <= 1'b1;
      end

      if (ss_lvl) begin
        bit_cnt   <= '0;
        hold_vld  <= 1'b0;
        tx_sr     <= IDLE_TX;
        slot_pend <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sr   <= {rx_sr[6:0], mosi_lvl};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
            byte_done <= 1'b1;
            slot_pend <= 1'b1;
          end
        end

        if (slot_edge) begin
          slot_pend <= 1'b0;
          hold_vld  <= 1'b0;
          if (ack_i) begin
            tx_sr <= data_i;
          end else if (hold_vld) begin
            tx_sr <= hold_q;
          end else begin
            tx_sr         <= IDLE_TX;
            tx_underrun_o <= 1'b1;
          end
        end else begin
          if (sck_fall) tx_sr <= {tx_sr[6:0], 1'b0};
          if (ack_i) begin
            hold_q   <= data_i;
            hold_vld <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_trx.sv
// Host-level SPI bench: drives whole bytes on the pins and checks pops, miso bytes and underruns.
module tb_spi_byte_trx;

  localparam int         SYNC = 2;
  localparam logic [7:0] IDLE = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss = 1'b1;
  logic       ack_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       miso, rst_o, ack_pop_o, tx_underrun_o;
  logic [7:0] data_o;

  always #5 clk = ~clk;

  spi_byte_trx #(.SYNC_STAGES(SYNC), .IDLE_TX(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .mosi(mosi), .ss(ss), .miso(miso),
    .rst_o(rst_o), .data_o(data_o), .ack_pop_o(ack_pop_o), .data_i(data_i),
    .ack_i(ack_i), .tx_underrun_o(tx_underrun_o)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_pop = 8'h00;
  int         under_cnt = 0;
  int         exp_under = 0;
  bit         mon_en = 1'b0;
  logic       ss_prev = 1'b1;
  int         ss_stable = 0;
  bit         first_in_sess = 1'b1;
  logic [7:0] nxt_tx = IDLE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: pops against the expected queue, data_o hold, deselect levels.
  initial forever begin
    @(posedge clk);
    #3;
    if (mon_en) begin
      if (ss !== ss_prev) ss_stable = 0;
      else if (ss_stable < 1000) ss_stable++;
      ss_prev = ss;
      if (ss_stable >= SYNC + 1) begin
        check("rst_o_level", rst_o, ss);
        if (ss) check("miso_deselected", miso, 1'b0);
      end
      if (tx_underrun_o) under_cnt++;
      if (ack_pop_o) begin
        check("pop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          last_pop = exp_q.pop_front();
          check("data_o_pop", data_o, last_pop);
        end
      end else begin
        check("data_o_hold", data_o, last_pop);
      end
    end
  end

  task automatic select_slave();
    ss = 1'b0;
    first_in_sess = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic deselect_slave();
    ss = 1'b1;
    first_in_sess = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // One byte slot (or nbits of it); acks go in the last high phase, bypass lands on the slot boundary.
  task automatic xfer(input logic [7:0] tx_b, input int nbits, input int nacks,
                      input logic [7:0] a0, input logic [7:0] a1, input bit byp,
                      input logic [7:0] bv, input int half, output logic [7:0] got);
    logic [7:0] exp_miso;
    exp_miso = first_in_sess ? IDLE : nxt_tx;
    got = 8'h00;
    if (nbits == 8) exp_q.push_back(tx_b);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx_b[7-i];
      repeat (half) @(negedge clk);
      got[7-i] = miso;
      sck = 1'b1;
      for (int c = 0; c < half; c++) begin
        @(negedge clk);
        ack_i  = (i == 7) && ((c == 4 && nacks >= 1) || (c == 5 && nacks >= 2));
        data_i = (c == 4) ? a0 : a1;
      end
      @(negedge clk);
      sck = 1'b0;
    end
    check("miso_byte", got >> (8 - nbits), exp_miso >> (8 - nbits));
    if (nbits == 8) begin
      if (byp) begin
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        ack_i = 1'b1;
        data_i = bv;
        @(negedge clk);
        ack_i = 1'b0;
      end
      first_in_sess = 1'b0;
      if (byp)             nxt_tx = bv;
      else if (nacks == 2) nxt_tx = a1;
      else if (nacks == 1) nxt_tx = a0;
      else begin
        nxt_tx = IDLE;
        exp_under++;
      end
      repeat (half) @(negedge clk);
      mosi = 1'b0;
      check("pops_drained", exp_q.size(), 0);
      check("underrun_count", under_cnt, exp_under);
    end
  endtask

  logic [7:0] got;
  int         r_half, r_nb, r_na;
  bit         r_byp;
  logic [7:0] r_tx, r_a0, r_a1, r_bv;

  initial begin
    #12;
    check("reset_rst_o", rst_o, 1'b1);
    check("reset_data_o", data_o, 8'h00);
    check("reset_ack_pop", ack_pop_o, 1'b0);
    check("reset_miso", miso, 1'b0);
    check("reset_underrun", tx_underrun_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_rst_o", rst_o, 1'b1);

    select_slave();
    xfer(8'hA5, 8, 1, 8'hCC, 8'h00, 1'b0, 8'h00, 10, got);
    check("b1_miso_idle", got, 8'h00);
    check("b1_data_o", data_o, 8'hA5);
    check("b1_no_underrun", under_cnt, 0);
    xfer(8'h3C, 8, 0, 8'h00, 8'h00, 1'b0, 8'h00, 10, got);
    check("b2_miso_cc", got, 8'hCC);
    check("b2_data_o", data_o, 8'h3C);
    check("b2_underrun_once", under_cnt, 1);
    xfer(8'h5A, 8, 2, 8'h11, 8'h22, 1'b0, 8'h00, 10, got);
    check("b3_miso_idle", got, 8'h00);
    xfer(8'h96, 8, 0, 8'h00, 8'h00, 1'b1, 8'h77, 10, got);
    check("b4_miso_last_wins", got, 8'h22);
    xfer(8'h0F, 8, 0, 8'h00, 8'h00, 1'b0, 8'h00, 10, got);
    check("b5_miso_bypass", got, 8'h77);
    check("b5_underrun_total", under_cnt, 2);
    xfer(8'hF0, 5, 0, 8'h00, 8'h00, 1'b0, 8'h00, 10, got);
    deselect_slave();
    check("abort_data_o_kept", data_o, 8'h0F);
    select_slave();
    xfer(8'h81, 8, 0, 8'h00, 8'h00, 1'b0, 8'h00, 10, got);
    check("b6_data_o", data_o, 8'h81);
    check("b6_miso_idle", got, 8'h00);

    for (int it = 0; it < 40; it++) begin
      r_half = $urandom_range(12, 8);
      r_nb   = ($urandom_range(9, 0) == 0) ? $urandom_range(7, 1) : 8;
      r_na   = $urandom_range(2, 0);
      r_byp  = ($urandom_range(5, 0) == 0);
      r_tx   = 8'($urandom);
      r_a0   = 8'($urandom);
      r_a1   = 8'($urandom);
      r_bv   = 8'($urandom);
      xfer(r_tx, r_nb, r_na, r_a0, r_a1, r_byp, r_bv, r_half, got);
      if (r_nb < 8 || $urandom_range(9, 0) == 0) begin
        deselect_slave();
        select_slave();
      end
    end
    deselect_slave();
    check("final_pops_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
